shadow_chain_collector: RTL and testbench

- Receiving end of the shadow-capture dump protocol.
- Selects one capture chain and drives its dump enable. Deserialises the returned chain bits into WORD_W-bit words and buffers them in a small FIFO for a host/debug reader.
- Sits in the sh_clk domain beside the per-unit shadow_capture instances and consumes their chain-out, chain-out-valid and chain-done triplets.

---
 rtl/shadow_dump_pkg.sv | 12 +
 rtl/shadow_word_fifo.sv | 41 ++++
 rtl/shadow_chain_collector.sv | 123 ++++++++++++
 tb/tb_shadow_chain_collector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_dump_pkg.sv
// shadow_dump_pkg: shared states, width helpers and defaults for the shadow dump collector
package shadow_dump_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, FINISH} state_t;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_TIMEOUT = 255;
  function automatic int cw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int nbw_f(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/shadow_word_fifo.sv
// shadow_word_fifo: small sync FIFO with registered occupancy, no fall-through
module shadow_word_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] free
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign free = (AW+1)'(DEPTH) - cnt;
  assign dout = mem[rp];
  // storage array, written on an accepted push
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers and occupancy; a pop on a full FIFO makes room for the same-cycle push
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/shadow_chain_collector.sv
// shadow_chain_collector: selects a capture chain, deserialises its bits into words and buffers them
module shadow_chain_collector
  import shadow_dump_pkg::*;
#(
  parameter int NUM_CHAINS = 4,
  parameter int WORD_W = DEF_WORD_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CW = cw_f(NUM_CHAINS),
  localparam int NBW = nbw_f(WORD_W),
  localparam int TW = $clog2(TIMEOUT + 1),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic sh_clk,
  input  logic sh_rst,
  input  logic start,
  input  logic [CW-1:0] chain_sel,
  output logic [NUM_CHAINS-1:0] dump_en,
  input  logic [NUM_CHAINS-1:0] ch_in,
  input  logic [NUM_CHAINS-1:0] ch_in_vld,
  input  logic [NUM_CHAINS-1:0] ch_in_done,
  output logic [WORD_W-1:0] word_data,
  output logic [NBW-1:0] word_nbits,
  output logic word_vld,
  input  logic word_rdy,
  output logic busy,
  output logic dump_done,
  output logic [15:0] bit_count,
  output logic err_overflow,
  output logic err_timeout
);
  localparam logic [(1<<CW)-1:0] LEGAL = {(1<<CW){1'b1}} >> ((1<<CW) - NUM_CHAINS);
  state_t state;
  logic [CW-1:0] sel;
  logic [WORD_W-1:0] shift, word, push_data;
  logic [NBW-1:0] ptr, push_nbits;
  logic [TW-1:0] idle;
  logic [AW:0] free;
  logic full, empty, push, pop, fit, accept, last, vld, done, timeout_hit, room;
  assign vld = ch_in_vld[sel];
  assign done = ch_in_done[sel];
  assign word = shift | (WORD_W'(ch_in[sel]) << ptr);
  assign word_vld = !empty;
  assign pop = word_vld & word_rdy;
  assign fit = !full | pop;
  assign room = free > (AW+1)'(1);
  assign accept = (state == COLLECT) & vld;
  assign last = ptr == NBW'(WORD_W - 1);
  assign timeout_hit = !accept & (idle == TW'(TIMEOUT - 1));
  assign push = (accept & last) | ((state == FLUSH) & (ptr != '0));
  assign push_nbits = (state == FLUSH) ? ptr : NBW'(WORD_W);
  assign push_data = (state == FLUSH) ? shift : word;
  assign busy = state != IDLE;
  shadow_word_fifo #(.W(NBW + WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(sh_clk),
    .rst(sh_rst),
    .push(push),
    .pop(pop),
    .din({push_nbits, push_data}),
    .dout({word_nbits, word_data}),
    .full(full),
    .empty(empty),
    .free(free)
  );
  // dump FSM with registered enables, counters and sticky error flags
  always_ff @(posedge sh_clk or posedge sh_rst)
    if (sh_rst) begin
      state <= IDLE;
      sel <= '0;
      shift <= '0;
      ptr <= '0;
      idle <= '0;
      dump_en <= '0;
      dump_done <= 1'b0;
      bit_count <= '0;
      err_overflow <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE:
          if (start && LEGAL[chain_sel]) begin
            state <= COLLECT;
            sel <= chain_sel;
            shift <= '0;
            ptr <= '0;
            idle <= '0;
            bit_count <= '0;
            err_overflow <= 1'b0;
            err_timeout <= 1'b0;
            dump_en <= room ? NUM_CHAINS'(1) << chain_sel : '0;
          end
        COLLECT: begin
          dump_en <= (room && !done && !timeout_hit) ? NUM_CHAINS'(1) << sel : '0;
          if (accept) begin
            idle <= '0;
            bit_count <= (bit_count == 16'hFFFF) ? bit_count : bit_count + 16'd1;
            ptr <= last ? '0 : ptr + 1'b1;
            shift <= last ? '0 : word;
            if (last && !fit) err_overflow <= 1'b1;
          end else
            idle <= idle + 1'b1;
          if (done)
            state <= FLUSH;
          else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state <= FLUSH;
          end
        end
        FLUSH:
          if (ptr == '0 || fit) begin
            ptr <= '0;
            shift <= '0;
            state <= FINISH;
          end
        FINISH: begin
          state <= IDLE;
          dump_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_shadow_chain_collector.sv
// tb_shadow_chain_collector: directed checks of dump collection, flush, back-pressure, timeout and reset
module tb_shadow_chain_collector;
  logic clk, rst, start, word_rdy;
  logic [1:0] chain_sel;
  logic [3:0] dump_en, ch_in, ch_in_vld, ch_in_done;
  logic [7:0] word_data;
  logic [3:0] word_nbits;
  logic word_vld, busy, dump_done, err_overflow, err_timeout;
  logic [15:0] bit_count;
  int checks = 0;
  int errors = 0;

  shadow_chain_collector #(.NUM_CHAINS(4), .WORD_W(8), .FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .sh_clk(clk),
    .sh_rst(rst),
    .start(start),
    .chain_sel(chain_sel),
    .dump_en(dump_en),
    .ch_in(ch_in),
    .ch_in_vld(ch_in_vld),
    .ch_in_done(ch_in_done),
    .word_data(word_data),
    .word_nbits(word_nbits),
    .word_vld(word_vld),
    .word_rdy(word_rdy),
    .busy(busy),
    .dump_done(dump_done),
    .bit_count(bit_count),
    .err_overflow(err_overflow),
    .err_timeout(err_timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] s);
    start = 1;
    chain_sel = s;
    tick();
    start = 0;
  endtask

  task automatic send(input int ch, input logic b, input logic d);
    ch_in = '0;
    ch_in_vld = '0;
    ch_in_done = '0;
    ch_in[ch] = b;
    ch_in_vld[ch] = 1;
    ch_in_done[ch] = d;
    tick();
    ch_in = '0;
    ch_in_vld = '0;
    ch_in_done = '0;
  endtask

  task automatic send_done(input int ch);
    ch_in_done = '0;
    ch_in_done[ch] = 1;
    tick();
    ch_in_done = '0;
  endtask

  task automatic send_byte(input int ch, input logic [7:0] v);
    for (int i = 0; i < 8; i++) send(ch, v[i], 0);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = dump_done;
    end
    chk(tag, seen, 1);
    tick();
    chk({tag, "_pulse"}, dump_done, 0);
  endtask

  task automatic pop_word(input string tag, input logic [7:0] d, input logic [3:0] n);
    chk({tag, "_vld"}, word_vld, 1);
    chk({tag, "_data"}, word_data, d);
    chk({tag, "_nbits"}, word_nbits, n);
    word_rdy = 1;
    tick();
    word_rdy = 0;
  endtask

  initial begin
    int n;
    logic [3:0] first_drop;
    logic [10:0] v11;
    rst = 1;
    start = 0;
    chain_sel = 0;
    word_rdy = 0;
    ch_in = 0;
    ch_in_vld = 0;
    ch_in_done = 0;
    tick();
    tick();
    chk("rst_dump_en", dump_en, 0);
    chk("rst_word_vld", word_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dump_done", dump_done, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_errs", {err_overflow, err_timeout}, 0);
    rst = 0;
    tick();

    do_start(2);
    chk("t1_dump_en", dump_en, 4'b0100);
    chk("t1_busy", busy, 1);
    send_byte(2, 8'h5A);
    send_byte(2, 8'hC3);
    chk("t1_bit_count", bit_count, 16);
    send_done(2);
    chk("t1_en_off", dump_en, 0);
    wait_done("t1_done");
    chk("t1_busy_off", busy, 0);
    pop_word("t1_w0", 8'h5A, 8);
    pop_word("t1_w1", 8'hC3, 8);
    chk("t1_empty", word_vld, 0);
    chk("t1_errs", {err_overflow, err_timeout}, 0);

    do_start(2);
    v11 = 11'b111_0110_1001;
    for (int i = 0; i < 11; i++) send(2, v11[i], 0);
    send_done(2);
    wait_done("t2_done");
    pop_word("t2_w0", 8'h69, 8);
    pop_word("t2_w1", 8'h07, 3);
    chk("t2_empty", word_vld, 0);
    chk("t2_bit_count", bit_count, 11);

    do_start(2);
    first_drop = 0;
    n = 0;
    for (int k = 1; k <= 6; k++)
      for (int i = 0; i < 8; i++) begin
        logic [7:0] b;
        b = 8'(8'h11 * k);
        send(2, b[i], 0);
        n++;
        if (dump_en == 0 && first_drop == 0) first_drop = 4'(n - 24);
      end
    chk("t3_en_drop_bit", first_drop, 1);
    chk("t3_overflow", err_overflow, 1);
    chk("t3_bit_count", bit_count, 48);
    send_done(2);
    wait_done("t3_done");
    for (int k = 1; k <= 4; k++) pop_word("t3_w", 8'(8'h11 * k), 8);
    chk("t3_empty", word_vld, 0);

    do_start(2);
    for (int k = 1; k <= 5; k++)
      for (int i = 0; i < 8; i++) begin
        logic [7:0] b;
        b = 8'(8'h11 * k);
        word_rdy = (k == 5 && i == 7);
        send(2, b[i], 0);
        word_rdy = 0;
      end
    chk("t3b_no_overflow", err_overflow, 0);
    send_done(2);
    wait_done("t3b_done");
    for (int k = 2; k <= 5; k++) pop_word("t3b_w", 8'(8'h11 * k), 8);
    chk("t3b_empty", word_vld, 0);

    do_start(2);
    send(1, 1, 0);
    chk("t4_ignore_vld", bit_count, 0);
    send_done(1);
    chk("t4_ignore_done", busy, 1);
    send(2, 1, 0);
    send(2, 0, 0);
    send(2, 1, 0);
    send(2, 1, 1);
    chk("t4_bit_count", bit_count, 4);
    wait_done("t4_done");
    pop_word("t4_w0", 8'h0D, 4);
    chk("t4_empty", word_vld, 0);

    do_start(0);
    n = 0;
    for (int i = 0; i < 400 && !err_timeout; i++) begin
      tick();
      n++;
    end
    chk("t5_timeout_flag", err_timeout, 1);
    chk("t5_timeout_cycles", n, 255);
    wait_done("t5_done");
    chk("t5_no_words", word_vld, 0);
    chk("t5_bit_count", bit_count, 0);

    do_start(3);
    send_byte(3, 8'hF0);
    send(3, 1, 0);
    send(3, 1, 0);
    chk("t6_pre_vld", word_vld, 1);
    rst = 1;
    #1;
    chk("t6_rst_dump_en", dump_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_vld", word_vld, 0);
    chk("t6_rst_bit_count", bit_count, 0);
    tick();
    rst = 0;
    tick();
    do_start(1);
    chk("t6_dump_en", dump_en, 4'b0010);
    send_byte(1, 8'hA5);
    send_done(1);
    wait_done("t6_done");
    pop_word("t6_w0", 8'hA5, 8);
    chk("t6_empty", word_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
